// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, access opcodes
// and mstatus field positions.
package csr_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_FFLAGS    = 12'h001;
  localparam logic [11:0] ADDR_FRM       = 12'h002;
  localparam logic [11:0] ADDR_FCSR      = 12'h003;
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_FS_LO  = 13;
  localparam int MSTATUS_FS_HI  = 14;

  // The top two address bits of 2'b11 mark the user read-only shadow space.
  function automatic logic addr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter with XLEN-wide half writes; a write to
// either half takes priority over the increment in that cycle.
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int HW = CNT_W - XLEN;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d[XLEN-1:0] = wdata_i;
    end else if (wr_hi_i) begin
      count_d[CNT_W-1:XLEN] = wdata_i[HW-1:0];
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: FP status, mstatus/mtvec/trap registers and the
// cycle/instret counters, with trap entry and mret sequencing.
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            fflags_valid,
  input  logic [4:0]      fflags_in,
  input  logic            instret_inc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_req,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o,
  output logic [2:0]      frm_o,
  output logic            mie_o
);

  localparam int HW = CNT_W - XLEN;

  csr_op_e op;

  logic [4:0]      fflags_q, fflags_d;
  logic [2:0]      frm_q, frm_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      fs_q, fs_d;
  logic [XLEN-3:0] mtvec_base_q, mtvec_base_d;
  logic            mtvec_mode_q, mtvec_mode_d;
  logic [XLEN-3:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic [CNT_W-1:0] mcycle, minstret;
  logic [XLEN-1:0]  mcycle_hi, minstret_hi;
  logic [XLEN-1:0]  mstatus_rd, old_val, new_val, vec_off;
  logic             addr_known, is_write, we, fp_we;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mcycle_hi   = '0;
    minstret_hi = '0;
    mcycle_hi[HW-1:0]   = mcycle[CNT_W-1:XLEN];
    minstret_hi[HW-1:0] = minstret[CNT_W-1:XLEN];
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_FS_HI:MSTATUS_FS_LO]   = fs_q;
  end

  always_comb begin
    addr_known = 1'b1;
    old_val    = '0;
    case (csr_addr)
      ADDR_FFLAGS:                   old_val[4:0] = fflags_q;
      ADDR_FRM:                      old_val[2:0] = frm_q;
      ADDR_FCSR:                     old_val[7:0] = {frm_q, fflags_q};
      ADDR_MSTATUS:                  old_val = mstatus_rd;
      ADDR_MTVEC:                    old_val = {mtvec_base_q, 1'b0, mtvec_mode_q};
      ADDR_MEPC:                     old_val = {mepc_q, 2'b00};
      ADDR_MCAUSE:                   old_val = mcause_q;
      ADDR_MTVAL:                    old_val = mtval_q;
      ADDR_MCYCLE, ADDR_CYCLE:       old_val = mcycle[XLEN-1:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:     old_val = mcycle_hi;
      ADDR_MINSTRET, ADDR_INSTRET:   old_val = minstret[XLEN-1:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret_hi;
      default:                       addr_known = 1'b0;
    endcase
  end

  // RS/RC with an all-zero mask is a pure read and never counts as a write.
  assign is_write    = (op == OP_RW) || ((op != OP_NONE) && (csr_wdata != '0));
  assign csr_illegal = (op != OP_NONE) &&
                       (!addr_known || (addr_is_ro(csr_addr) && is_write));
  assign csr_rdata   = csr_illegal ? '0 : old_val;
  assign we          = is_write && !csr_illegal;
  assign fp_we       = we && ((csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FRM) ||
                              (csr_addr == ADDR_FCSR));

  always_comb begin
    case (op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    fflags_d     = fflags_q;
    frm_d        = frm_q;
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    fs_d         = fs_q;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;

    if (we && ((csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FCSR))) fflags_d = new_val[4:0];
    if (we && (csr_addr == ADDR_FRM))  frm_d = new_val[2:0];
    if (we && (csr_addr == ADDR_FCSR)) frm_d = new_val[7:5];
    if (fflags_valid) fflags_d = fflags_d | fflags_in;

    if (we && (csr_addr == ADDR_MTVEC)) begin
      mtvec_base_d = new_val[XLEN-1:2];
      mtvec_mode_d = new_val[0];
    end

    // Trap entry outranks mret, which outranks software writes to trap state.
    if (trap_req) begin
      mepc_d   = trap_pc[XLEN-1:2];
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_req) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE];
          fs_d   = new_val[MSTATUS_FS_HI:MSTATUS_FS_LO];
        end
        ADDR_MEPC:   mepc_d   = new_val[XLEN-1:2];
        ADDR_MCAUSE: mcause_d = new_val;
        ADDR_MTVAL:  mtval_d  = new_val;
        default: ;
      endcase
    end

    if (fflags_valid || fp_we) fs_d = 2'b11;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags_q     <= '0;
      frm_q        <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      fs_q         <= '0;
      mtvec_base_q <= '0;
      mtvec_mode_q <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      fflags_q     <= fflags_d;
      frm_q        <= frm_d;
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      fs_q         <= fs_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (we && (csr_addr == ADDR_MCYCLE)),
    .wr_hi_i (we && (csr_addr == ADDR_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (mcycle)
  );

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (instret_inc),
    .wr_lo_i (we && (csr_addr == ADDR_MINSTRET)),
    .wr_hi_i (we && (csr_addr == ADDR_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (minstret)
  );

  // Vectored mode only offsets interrupts, indexed by the latched cause.
  always_comb begin
    vec_off = '0;
    if (mtvec_mode_q && mcause_q[XLEN-1]) vec_off[7:2] = mcause_q[5:0];
  end

  assign trap_vector = {mtvec_base_q, 2'b00} + vec_off;
  assign mepc_o      = {mepc_q, 2'b00};
  assign frm_o       = frm_q;
  assign mie_o       = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed vector table, trap/counter/reset sequences and
// randomized traffic checked against an architectural model of the CSR state.
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        fflags_valid;
  logic [4:0]  fflags_in;
  logic        instret_inc;
  logic        trap_req;
  logic [31:0] trap_pc, trap_cause, trap_val;
  logic        mret_req;
  logic [31:0] trap_vector, mepc_o;
  logic [2:0]  frm_o;
  logic        mie_o;

  csr_file #(.XLEN(32), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .fflags_valid (fflags_valid),
    .fflags_in    (fflags_in),
    .instret_inc  (instret_inc),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .trap_val     (trap_val),
    .mret_req     (mret_req),
    .trap_vector  (trap_vector),
    .mepc_o       (mepc_o),
    .frm_o        (frm_o),
    .mie_o        (mie_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model state ----------------
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic        m_mie, m_mpie;
  logic [1:0]  m_fs;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  task automatic model_clear();
    m_fflags = '0; m_frm = '0; m_mie = 1'b0; m_mpie = 1'b0; m_fs = '0;
    m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
    m_mcycle = '0; m_minstret = '0;
  endtask

  function automatic void model_read(input logic [11:0] a, output bit known,
                                     output bit ro, output logic [31:0] v);
    known = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'h001: v = {27'd0, m_fflags};
      12'h002: v = {29'd0, m_frm};
      12'h003: v = {24'd0, m_frm, m_fflags};
      12'h300: v = (32'(m_mie) << 3) | (32'(m_mpie) << 7) | (32'd3 << 11) | (32'(m_fs) << 13);
      12'h305: v = m_mtvec;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00: v = m_mcycle[31:0];
      12'hB80: v = m_mcycle[63:32];
      12'hB02: v = m_minstret[31:0];
      12'hB82: v = m_minstret[63:32];
      12'hC00: begin v = m_mcycle[31:0];    ro = 1'b1; end
      12'hC80: begin v = m_mcycle[63:32];   ro = 1'b1; end
      12'hC02: begin v = m_minstret[31:0];  ro = 1'b1; end
      12'hC82: begin v = m_minstret[63:32]; ro = 1'b1; end
      default: known = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_tvec();
    logic [31:0] b;
    b = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0] && m_mcause[31]) b = b + 32'd4 * {26'd0, m_mcause[5:0]};
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "trap_vector"}, trap_vector, exp_tvec());
    check({tag, "mepc_o"}, mepc_o, m_mepc);
    check({tag, "frm_o"}, {29'd0, frm_o}, {29'd0, m_frm});
    check({tag, "mie_o"}, {31'd0, mie_o}, {31'd0, m_mie});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    csr_op = 2'd0; csr_addr = '0; csr_wdata = '0;
    fflags_valid = 1'b0; fflags_in = '0; instret_inc = 1'b0;
    trap_req = 1'b0; trap_pc = '0; trap_cause = '0; trap_val = '0; mret_req = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_op = op; csr_addr = a; csr_wdata = wd;
  endtask

  // One clock: check the combinational read against the model, advance the
  // model with the applied inputs, then check the registered views.
  task automatic cycle();
    bit known, ro, wr, ill, doit;
    logic [31:0] old, nv;
    logic [63:0] n_mc, n_mi;
    #1;
    model_read(csr_addr, known, ro, old);
    wr   = (csr_op == 2'd1) || ((csr_op != 2'd0) && (csr_wdata != 32'd0));
    ill  = (csr_op != 2'd0) && (!known || (ro && wr));
    doit = wr && !ill;
    check("rdata", csr_rdata, ill ? 32'd0 : old);
    check("illegal", {31'd0, csr_illegal}, {31'd0, ill});
    nv = (csr_op == 2'd1) ? csr_wdata :
         (csr_op == 2'd2) ? (old | csr_wdata) : (old & ~csr_wdata);

    n_mc = m_mcycle + 64'd1;
    n_mi = m_minstret + (instret_inc ? 64'd1 : 64'd0);
    if (doit && csr_addr == 12'hB00) n_mc = {m_mcycle[63:32], nv};
    if (doit && csr_addr == 12'hB80) n_mc = {nv, m_mcycle[31:0]};
    if (doit && csr_addr == 12'hB02) n_mi = {m_minstret[63:32], nv};
    if (doit && csr_addr == 12'hB82) n_mi = {nv, m_minstret[31:0]};

    if (doit && (csr_addr == 12'h001 || csr_addr == 12'h003)) m_fflags = nv[4:0];
    if (doit && csr_addr == 12'h002) m_frm = nv[2:0];
    if (doit && csr_addr == 12'h003) m_frm = nv[7:5];
    if (doit && (csr_addr == 12'h001 || csr_addr == 12'h002 || csr_addr == 12'h003)) m_fs = 2'b11;
    if (fflags_valid) m_fflags = m_fflags | fflags_in;
    if (doit && csr_addr == 12'h305) m_mtvec = nv & ~32'h2;

    if (trap_req) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret_req) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (doit) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; m_fs = nv[14:13]; end
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
    if (fflags_valid) m_fs = 2'b11;
    m_mcycle = n_mc;
    m_minstret = n_mi;

    @(posedge clk);
    #1;
    check_regs("");
    idle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fin;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[23];
  logic [11:0] addr_list[20];

  initial begin
    tbl[0]  = '{2'd2, 12'h003, 32'h0000_000A, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[1]  = '{2'd2, 12'h003, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_000A, 1'b0};
    tbl[2]  = '{2'd2, 12'h002, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[3]  = '{2'd2, 12'h300, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_7800, 1'b0};
    tbl[4]  = '{2'd1, 12'h001, 32'h0000_0010, 1'b1, 5'd1,  32'h0000_000A, 1'b0};
    tbl[5]  = '{2'd2, 12'h001, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0011, 1'b0};
    tbl[6]  = '{2'd1, 12'h002, 32'h0000_0005, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[7]  = '{2'd2, 12'h003, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_00B1, 1'b0};
    tbl[8]  = '{2'd1, 12'hC00, 32'h0000_0005, 1'b0, 5'd0,  32'h0000_0000, 1'b1};
    tbl[9]  = '{2'd2, 12'h7FF, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b1};
    tbl[10] = '{2'd3, 12'h003, 32'h0000_00FF, 1'b0, 5'd0,  32'h0000_00B1, 1'b0};
    tbl[11] = '{2'd2, 12'h003, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[12] = '{2'd1, 12'h305, 32'h0000_0103, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[13] = '{2'd2, 12'h305, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0101, 1'b0};
    tbl[14] = '{2'd1, 12'h341, 32'h0000_1237, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[15] = '{2'd2, 12'h341, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_1234, 1'b0};
    tbl[16] = '{2'd1, 12'h300, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0000_7800, 1'b0};
    tbl[17] = '{2'd2, 12'h300, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_7888, 1'b0};
    tbl[18] = '{2'd3, 12'h300, 32'h0000_0008, 1'b0, 5'd0,  32'h0000_7888, 1'b0};
    tbl[19] = '{2'd2, 12'h300, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_7880, 1'b0};
    tbl[20] = '{2'd3, 12'hC82, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[21] = '{2'd2, 12'hC02, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    tbl[22] = '{2'd2, 12'hC02, 32'h0000_0001, 1'b0, 5'd0,  32'h0000_0000, 1'b1};

    addr_list = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h305, 12'h341, 12'h342,
                  12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                  12'hC02, 12'hC82, 12'h000, 12'h301, 12'h7C0, 12'hC01};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst = 1'b0;
    #1;
    model_clear();
    check_regs("rst_");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // First cycle after release still reads 0; the increment lands on that edge.
    csr(2'd2, 12'hB00, 32'd0);
    #1;
    check("cycle_first_read", csr_rdata, 32'd0);
    cycle();
    csr(2'd2, 12'hB00, 32'd0);
    #1;
    check("cycle_after_first_edge", csr_rdata, 32'd1);
    cycle();

    for (int i = 0; i < 23; i++) begin
      csr(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      fflags_valid = tbl[i].fv;
      fflags_in    = tbl[i].fin;
      #1;
      check($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, tbl[i].exp_ill});
      cycle();
    end

    // Trap entry with a same-cycle mepc write that must lose, then mret.
    csr(2'd2, 12'h300, 32'h8);
    cycle();
    csr(2'd1, 12'h341, 32'h4000);
    trap_req = 1'b1; trap_pc = 32'h1002; trap_cause = 32'h8000_0003; trap_val = 32'hDEAD;
    cycle();
    check("trap_mepc", mepc_o, 32'h1000);
    check("trap_mie", {31'd0, mie_o}, 32'd0);
    check("trap_vector_vectored", trap_vector, 32'h10C);
    csr(2'd2, 12'h300, 32'd0);
    #1;
    check("trap_mstatus", csr_rdata, 32'h7880);
    cycle();
    mret_req = 1'b1;
    cycle();
    check("mret_mie", {31'd0, mie_o}, 32'd1);

    // mcycle wrap: all-ones in both halves rolls to 0, then 1.
    csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
    cycle();
    csr(2'd1, 12'hB80, 32'hFFFF_FFFF);
    cycle();
    cycle();
    cycle();
    csr(2'd2, 12'hB00, 32'd0);
    #1;
    check("mcycle_wrap_lo", csr_rdata, 32'd1);
    cycle();
    csr(2'd2, 12'hB80, 32'd0);
    #1;
    check("mcycle_wrap_hi", csr_rdata, 32'd0);
    cycle();
    csr(2'd1, 12'hC00, 32'd5);
    cycle();
    csr(2'd2, 12'hB00, 32'd0);
    #1;
    check("mcycle_after_illegal", csr_rdata, 32'd4);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      csr_op       = 2'($urandom_range(0, 3));
      csr_addr     = addr_list[$urandom_range(0, 19)];
      csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      fflags_valid = ($urandom_range(0, 3) == 0);
      fflags_in    = 5'($urandom_range(0, 31));
      instret_inc  = 1'($urandom_range(0, 1));
      trap_req     = ($urandom_range(0, 11) == 0);
      trap_pc      = $urandom();
      trap_cause   = {1'($urandom_range(0, 1)), 25'd0, 6'($urandom_range(0, 63))};
      trap_val     = $urandom();
      mret_req     = ($urandom_range(0, 11) == 0);
      cycle();
    end

    // Reset asserted in the middle of a trap request.
    csr(2'd2, 12'h300, 32'h8);
    cycle();
    trap_req = 1'b1; trap_pc = 32'h2000; trap_cause = 32'h5; trap_val = 32'h77;
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check("rst_async_mie", {31'd0, mie_o}, 32'd0);
    check("rst_async_mepc", mepc_o, 32'd0);
    check("rst_async_tvec", trap_vector, 32'd0);
    check("rst_async_frm", {29'd0, frm_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    check_regs("rst_hold_");
    csr(2'd2, 12'h342, 32'd0);
    cycle();
    csr(2'd2, 12'h300, 32'd0);
    #1;
    check("rst_mstatus", csr_rdata, 32'h1800);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
